// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: issues one valid/ack data-memory access per EX/MEM request,
// aligns/extends load data for MEM/WB and stalls the upstream pipeline while busy.
module mem_access_unit #(
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  i_rst,
  input  logic                  i_valid,
  input  logic                  i_mem_read,
  input  logic                  i_mem_write,
  input  logic [2:0]            i_funct3,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  input  logic [31:0]           i_wdata,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [3:0]            o_mem_be,
  output logic [31:0]           o_mem_wdata,
  input  logic                  i_mem_ack,
  input  logic [31:0]           i_mem_rdata,
  output logic [31:0]           o_data,
  output logic                  o_stall,
  output logic                  o_done,
  output logic                  o_exc,
  output logic                  o_bus_err
);

  localparam int unsigned TimerWidth = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam bit          TimeoutEn  = (ACK_TIMEOUT != 0);
  localparam logic [TimerWidth-1:0] TimerLast =
      TimerWidth'((ACK_TIMEOUT == 0) ? 0 : ACK_TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  state_e                  r_state, w_state_nxt;
  logic [TimerWidth-1:0]   r_timer;
  logic                    r_mem_req, r_mem_we, r_done, r_bus_err, r_uns;
  logic [ADDR_WIDTH-1:0]   r_mem_addr;
  logic [3:0]              r_mem_be;
  logic [31:0]             r_mem_wdata, r_data;
  logic [1:0]              r_size, r_off;

  logic        w_is_mem, w_illegal, w_misal, w_idle, w_start, w_fin_ack, w_fin_to;
  logic [1:0]  w_size;
  logic [3:0]  w_be;
  logic [31:0] w_wdata, w_lane, w_ld_data;

  // Width decode and exception detection; a store with funct3[2] set has no meaning.
  assign w_size    = i_funct3[1:0];
  assign w_is_mem  = i_valid & (i_mem_read | i_mem_write);
  assign w_illegal = (w_size == 2'b11) | (i_mem_write & i_funct3[2]);
  assign w_misal   = ((w_size == 2'b01) & i_addr[0]) |
                     ((w_size == 2'b10) & (i_addr[1:0] != 2'b00));
  assign w_idle    = (r_state == StIdle);
  assign o_exc     = ~i_rst & w_idle & w_is_mem & (w_illegal | w_misal);
  assign w_start   = ~i_rst & w_idle & w_is_mem & ~(w_illegal | w_misal);

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = i_wdata;
    unique case (w_size)
      2'b00: begin
        w_be    = 4'b0001 << i_addr[1:0];
        w_wdata = {4{i_wdata[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {i_addr[1], 1'b0};
        w_wdata = {2{i_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  // Halves are always 2-byte aligned here, so a byte-granular shift serves both widths.
  always_comb begin
    w_lane    = i_mem_rdata >> {r_off, 3'b000};
    w_ld_data = i_mem_rdata;
    unique case (r_size)
      2'b00:   w_ld_data = {{24{~r_uns & w_lane[7]}}, w_lane[7:0]};
      2'b01:   w_ld_data = {{16{~r_uns & w_lane[15]}}, w_lane[15:0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (i_rst) r_state <= StIdle;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    o_stall     = 1'b0;
    w_fin_ack   = 1'b0;
    w_fin_to    = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_stall = w_start;
        if (w_start) w_state_nxt = StBusy;
      end
      StBusy: begin
        o_stall = 1'b1;
        if (i_mem_ack) begin
          w_fin_ack   = 1'b1;
          w_state_nxt = StDone;
        end else if (TimeoutEn && (r_timer == TimerLast)) begin
          w_fin_to    = 1'b1;
          w_state_nxt = StDone;
        end
      end
      StDone:  w_state_nxt = StIdle;
      default: w_state_nxt = StIdle;
    endcase
    if (i_rst) o_stall = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (i_rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_be    <= 4'b0000;
      r_mem_wdata <= 32'h0;
      r_data      <= 32'h0;
      r_done      <= 1'b0;
      r_bus_err   <= 1'b0;
      r_timer     <= '0;
      r_size      <= 2'b00;
      r_off       <= 2'b00;
      r_uns       <= 1'b0;
    end else begin
      r_done    <= w_fin_ack | w_fin_to;
      r_bus_err <= w_fin_to;
      if (w_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= i_mem_write;
        r_mem_addr  <= {i_addr[ADDR_WIDTH-1:2], 2'b00};
        r_mem_be    <= w_be;
        r_mem_wdata <= w_wdata;
        r_size      <= w_size;
        r_off       <= i_addr[1:0];
        r_uns       <= i_funct3[2];
        r_timer     <= '0;
      end else if (w_fin_ack | w_fin_to) begin
        r_mem_req <= 1'b0;
      end else if (r_state == StBusy) begin
        r_timer <= r_timer + TimerWidth'(1);
      end
      if (w_fin_ack & ~r_mem_we) r_data <= w_ld_data;
      if (w_fin_to)              r_data <= 32'h0;
    end
  end

  assign o_mem_req   = r_mem_req;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_be    = r_mem_be;
  assign o_mem_wdata = r_mem_wdata;
  assign o_data      = r_data;
  assign o_done      = r_done;
  assign o_bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed and randomised load/store transactions against mem_access_unit with a result
// scoreboard; built with an 8-cycle ack timeout so the timeout path is reachable.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0, i_mem_read = 1'b0, i_mem_write = 1'b0;
  logic [2:0]  i_funct3 = 3'b000;
  logic [31:0] i_addr = 32'h0, i_wdata = 32'h0;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr;
  logic [3:0]  o_mem_be;
  logic [31:0] o_mem_wdata;
  logic        i_mem_ack = 1'b0;
  logic [31:0] i_mem_rdata = 32'h0;
  logic [31:0] o_data;
  logic        o_stall, o_done, o_exc, o_bus_err;

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_data = 32'h0;

  mem_access_unit #(.ADDR_WIDTH(32), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_mem_read(i_mem_read),
    .i_mem_write(i_mem_write), .i_funct3(i_funct3), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_be(o_mem_be), .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack),
    .i_mem_rdata(i_mem_rdata), .o_data(o_data), .o_stall(o_stall), .o_done(o_done),
    .o_exc(o_exc), .o_bus_err(o_bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f3, input logic [31:0] a,
                                           input logic [31:0] rd);
    logic [31:0] sh;
    sh = rd >> (8 * a[1:0]);
    case (f3)
      3'b000:  return {{24{sh[7]}}, sh[7:0]};
      3'b100:  return {24'h0, sh[7:0]};
      3'b001:  return {{16{sh[15]}}, sh[15:0]};
      3'b101:  return {16'h0, sh[15:0]};
      default: return rd;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'b00:   return 4'b0001 << a[1:0];
      2'b01:   return 4'b0011 << a[1:0];
      default: return 4'b1111;
    endcase
  endfunction

  // One full transaction: drive in IDLE, ack on BUSY cycle ack_at (0 = first), check DONE.
  task automatic run_access(input string tag, input logic rd, input logic wr,
                            input logic [2:0] f3, input logic [31:0] addr,
                            input logic [31:0] wd, input logic [31:0] rdata, input int ack_at,
                            input int exp_stalls, input logic [3:0] exp_be,
                            input logic [31:0] exp_wd, input logic [31:0] exp_data,
                            input logic exp_err);
    int stalls = 0;
    int reqs = 0;
    bit seen_done = 0;
    logic [31:0] exp_d;
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3;
    i_addr = addr; i_wdata = wd;
    sb_q.push_back(exp_data);
    #1;
    chk({tag, ".exc"}, 32'(o_exc), 32'd0);
    if (o_stall) stalls++;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      @(negedge clk);
      i_mem_ack = 1'b0;
      #1;
      if (o_done) begin
        seen_done = 1;
      end else begin
        if (o_stall) stalls++;
        if (o_mem_req) reqs++;
        if (c == 0) begin
          chk({tag, ".addr"}, o_mem_addr, {addr[31:2], 2'b00});
          chk({tag, ".be"}, 32'(o_mem_be), 32'(exp_be));
          chk({tag, ".we"}, 32'(o_mem_we), 32'(wr));
          if (wr) chk({tag, ".wdata"}, o_mem_wdata, exp_wd);
        end
        if (c == ack_at) begin
          i_mem_ack = 1'b1;
          i_mem_rdata = rdata;
        end
      end
    end
    chk({tag, ".done_seen"}, 32'(seen_done), 32'd1);
    chk({tag, ".stalls"}, 32'(stalls), 32'(exp_stalls));
    chk({tag, ".req_cycles"}, 32'(reqs), 32'(exp_stalls - 1));
    chk({tag, ".done_stall"}, 32'(o_stall), 32'd0);
    chk({tag, ".done_req"}, 32'(o_mem_req), 32'd0);
    chk({tag, ".bus_err"}, 32'(o_bus_err), 32'(exp_err));
    if (sb_q.size() == 0) begin
      chk({tag, ".sb_empty"}, 32'd0, 32'd1);
    end else begin
      exp_d = sb_q.pop_front();
      chk({tag, ".data"}, o_data, exp_d);
      last_data = exp_d;
    end
    // i_valid is still high during DONE and must be ignored; now let it drop.
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    @(negedge clk);
    #1;
    chk({tag, ".done_pulse"}, 32'(o_done), 32'd0);
    chk({tag, ".idle_req"}, 32'(o_mem_req), 32'd0);
  endtask

  task automatic exc_case(input string tag, input logic rd, input logic wr,
                          input logic [2:0] f3, input logic [31:0] addr);
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = rd; i_mem_write = wr; i_funct3 = f3; i_addr = addr;
    #1;
    chk({tag, ".exc"}, 32'(o_exc), 32'd1);
    chk({tag, ".stall"}, 32'(o_stall), 32'd0);
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      #1;
      chk({tag, ".req"}, 32'(o_mem_req), 32'd0);
    end
    chk({tag, ".data_held"}, o_data, last_data);
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
  endtask

  initial begin
    logic [2:0]  f3_tab [5];
    logic [2:0]  f3;
    logic [31:0] a, rd;
    int          w;
    f3_tab = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};

    // Reset with a misaligned request present: o_exc and o_stall forced low.
    i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h102;
    @(negedge clk);
    #1;
    chk("rst.exc", 32'(o_exc), 32'd0);
    chk("rst.stall", 32'(o_stall), 32'd0);
    chk("rst.req", 32'(o_mem_req), 32'd0);
    chk("rst.data", o_data, 32'h0);
    chk("rst.done", 32'(o_done), 32'd0);
    chk("rst.be", 32'(o_mem_be), 32'd0);
    i_valid = 1'b0; i_mem_read = 1'b0;
    @(negedge clk);
    i_rst = 1'b0;

    run_access("lw100", 1, 0, 3'b010, 32'h100, 0, 32'hDEADBEEF, 0, 2, 4'b1111, 0,
               32'hDEADBEEF, 0);
    run_access("lb103", 1, 0, 3'b000, 32'h103, 0, 32'h80000000, 0, 2, 4'b1000, 0,
               32'hFFFFFF80, 0);
    run_access("lbu103", 1, 0, 3'b100, 32'h103, 0, 32'h80000000, 1, 3, 4'b1000, 0,
               32'h00000080, 0);
    run_access("lh102", 1, 0, 3'b001, 32'h102, 0, 32'h7FFF0000, 0, 2, 4'b1100, 0,
               32'h00007FFF, 0);
    run_access("sb201", 0, 1, 3'b000, 32'h201, 32'h000000AB, 32'h0, 3, 5, 4'b0010,
               32'hABABABAB, last_data, 0);
    run_access("sh202", 0, 1, 3'b001, 32'h202, 32'h1234CAFE, 32'h0, 0, 2, 4'b1100,
               32'hCAFECAFE, last_data, 0);
    // Both read and write high: handled as a store.
    run_access("rdwr", 1, 1, 3'b010, 32'h40, 32'h12345678, 32'h55555555, 0, 2, 4'b1111,
               32'h12345678, last_data, 0);

    exc_case("lw102", 1, 0, 3'b010, 32'h102);
    exc_case("sh101", 0, 1, 3'b001, 32'h101);
    exc_case("f3_011", 1, 0, 3'b011, 32'h100);
    exc_case("sbu", 0, 1, 3'b100, 32'h100);

    // Non-memory instruction: no stall, no request.
    @(negedge clk);
    i_valid = 1'b1;
    #1;
    chk("nonmem.stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    #1;
    chk("nonmem.req", 32'(o_mem_req), 32'd0);
    i_valid = 1'b0;

    run_access("timeout", 1, 0, 3'b010, 32'h300, 0, 32'h0, 100, 9, 4'b1111, 0, 32'h0, 1);

    for (int k = 0; k < 6; k++) begin
      f3 = f3_tab[$urandom_range(0, 4)];
      a  = $urandom & 32'h0000_0FFC;
      if (f3[1:0] == 2'b00) a = a | 32'($urandom_range(0, 3));
      if (f3[1:0] == 2'b01) a = a | 32'(2 * $urandom_range(0, 1));
      rd = $urandom;
      w  = $urandom_range(0, 3);
      run_access("rnd", 1, 0, f3, a, 0, rd, w, 2 + w, be_model(f3, a), 0,
                 ld_model(f3, a, rd), 0);
    end

    // Reset on the second BUSY cycle, then a late ack.
    @(negedge clk);
    i_valid = 1'b1; i_mem_read = 1'b1; i_funct3 = 3'b010; i_addr = 32'h500;
    @(negedge clk);
    @(negedge clk);
    i_rst = 1'b1;
    #1;
    chk("rstbusy.stall", 32'(o_stall), 32'd0);
    @(negedge clk);
    i_rst = 1'b0; i_valid = 1'b0; i_mem_read = 1'b0;
    i_mem_ack = 1'b1; i_mem_rdata = 32'hFFFFFFFF;
    #1;
    chk("rstbusy.req", 32'(o_mem_req), 32'd0);
    chk("rstbusy.stall_after", 32'(o_stall), 32'd0);
    @(negedge clk);
    i_mem_ack = 1'b0;
    #1;
    chk("rstbusy.done", 32'(o_done), 32'd0);
    chk("rstbusy.data", o_data, 32'h0);
    last_data = 32'h0;

    run_access("lw_after_rst", 1, 0, 3'b010, 32'h104, 0, 32'hA5A5_0F0F, 0, 2, 4'b1111, 0,
               32'hA5A5_0F0F, 0);

    chk("sb.drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
